// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline, plus the mult/div
// busy sequencer that holds back HI/LO users while the unit is occupied.
module pipeline_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [1:0] tuse_rs_d,
    input  logic [1:0] tuse_rt_d,
    input  logic [4:0] rs_e,
    input  logic [4:0] rt_e,
    input  logic [4:0] wa_e,
    input  logic [4:0] wa_m,
    input  logic [4:0] wa_w,
    input  logic [1:0] tnew_e,
    input  logic [1:0] tnew_m,
    input  logic       md_start_e,
    input  logic       md_is_div_e,
    input  logic       md_use_d,
    output logic       stall,
    output logic       flush_e,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic       md_busy
);

    localparam int CW = $clog2(DIV_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    md_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic rs_d_hazard;
    logic rt_d_hazard;
    logic md_hazard;

    // A source with tuse 3 is not read at all; register 0 is hardwired and never a hazard.
    always_comb begin
        rs_d_hazard = 1'b0;
        rt_d_hazard = 1'b0;
        if (rs_d != 5'd0 && tuse_rs_d != 2'd3) begin
            rs_d_hazard = (rs_d == wa_e && tuse_rs_d < tnew_e) ||
                          (rs_d == wa_m && tuse_rs_d < tnew_m);
        end
        if (rt_d != 5'd0 && tuse_rt_d != 2'd3) begin
            rt_d_hazard = (rt_d == wa_e && tuse_rt_d < tnew_e) ||
                          (rt_d == wa_m && tuse_rt_d < tnew_m);
        end
        md_hazard = md_use_d && (md_busy || md_start_e);
        stall     = rs_d_hazard || rt_d_hazard || md_hazard;
        flush_e   = stall;
    end

    // Nearest producer wins; the E-stage producer is never a forwarding source.
    always_comb begin
        fwd_rs_d = 2'd0;
        fwd_rt_d = 2'd0;
        fwd_rs_e = 2'd0;
        fwd_rt_e = 2'd0;
        if (rs_d != 5'd0) begin
            if (rs_d == wa_m && tnew_m == 2'd0) fwd_rs_d = 2'd1;
            else if (rs_d == wa_w)              fwd_rs_d = 2'd2;
        end
        if (rt_d != 5'd0) begin
            if (rt_d == wa_m && tnew_m == 2'd0) fwd_rt_d = 2'd1;
            else if (rt_d == wa_w)              fwd_rt_d = 2'd2;
        end
        if (rs_e != 5'd0) begin
            if (rs_e == wa_m && tnew_m == 2'd0) fwd_rs_e = 2'd1;
            else if (rs_e == wa_w)              fwd_rs_e = 2'd2;
        end
        if (rt_e != 5'd0) begin
            if (rt_e == wa_m && tnew_m == 2'd0) fwd_rt_e = 2'd1;
            else if (rt_e == wa_w)              fwd_rt_e = 2'd2;
        end
    end

    // A start seen while busy cannot happen in a correct pipeline, so it is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (md_start_e) begin
                    state_d = MD_BUSY;
                    cnt_d   = md_is_div_e ? DIV_LOAD : MULT_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign md_busy = (state_q == MD_BUSY);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed pipeline scenarios
// followed by randomized traffic compared against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wa_e, wa_m, wa_w;
    logic [1:0] tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
    logic       md_start_e, md_is_div_e, md_use_d;
    logic       stall, flush_e, md_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    int vectors    = 0;
    int miscompares = 0;
    int md_rem     = 0;

    pipeline_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .rst(rst),
        .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
        .rs_e(rs_e), .rt_e(rt_e), .wa_e(wa_e), .wa_m(wa_m), .wa_w(wa_w),
        .tnew_e(tnew_e), .tnew_m(tnew_m),
        .md_start_e(md_start_e), .md_is_div_e(md_is_div_e), .md_use_d(md_use_d),
        .stall(stall), .flush_e(flush_e),
        .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    // Reference model: hazard rules as plain arithmetic, mult/div as a remaining-cycle count.
    function automatic logic m_src_stall(input logic [4:0] r, input logic [1:0] tuse);
        if (r == 5'd0 || tuse == 2'd3) return 1'b0;
        return (r == wa_e && int'(tuse) < int'(tnew_e)) || (r == wa_m && int'(tuse) < int'(tnew_m));
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        if (r == 5'd0) return 2'd0;
        if (r == wa_m && tnew_m == 2'd0) return 2'd1;
        if (r == wa_w) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [10:0] m_expected();
        logic busy;
        logic stl;
        busy = (md_rem > 0);
        stl  = m_src_stall(rs_d, tuse_rs_d) | m_src_stall(rt_d, tuse_rt_d) |
               (md_use_d & (busy | md_start_e));
        return {stl, stl, m_fwd(rs_d), m_fwd(rt_d), m_fwd(rs_e), m_fwd(rt_e), busy};
    endfunction

    task automatic clear_inputs();
        rst = 1'b0;
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0; wa_e = 0; wa_m = 0; wa_w = 0;
        tuse_rs_d = 2'd3; tuse_rt_d = 2'd3; tnew_e = 0; tnew_m = 0;
        md_start_e = 0; md_is_div_e = 0; md_use_d = 0;
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic drive_phase();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) md_rem = 0;
        else if (md_rem > 0) md_rem = md_rem - 1;
        else if (md_start_e) md_rem = md_is_div_e ? DIV_N : MULT_N;
    endtask

    task automatic test_reset();
        drive_phase();
        clear_inputs();
        rst = 1'b1;
        tick();
        drive_phase();
        rst = 1'b0;
        tuse_rs_d = 0; tuse_rt_d = 0;
        #1;
        vectors++;
        if ({stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy} !== 11'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %b want %b",
                     {stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy}, 11'd0);
        end
        tick();
    endtask

    task automatic test_load_use();
        drive_phase();
        clear_inputs();
        wa_e = 5'd1; tnew_e = 2'd2; rs_d = 5'd1; tuse_rs_d = 2'd1;
        #1;
        vectors++;
        if (stall !== 1'b1 || flush_e !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL load_use_stall: got stall=%b flush=%b want 1/1", stall, flush_e);
        end
        tick();
        drive_phase();
        wa_e = 5'd0; tnew_e = 2'd0; wa_m = 5'd1; tnew_m = 2'd1;
        #1;
        vectors++;
        if (stall !== 1'b0 || flush_e !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_use_release: got stall=%b flush=%b want 0/0", stall, flush_e);
        end
        tick();
        drive_phase();
        wa_m = 5'd0; tnew_m = 2'd0; wa_w = 5'd1; rs_d = 5'd0; rs_e = 5'd1;
        #1;
        vectors++;
        if (fwd_rs_e !== 2'd2 || stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_use_fwd_w: got fwd_rs_e=%0d stall=%b want 2/0", fwd_rs_e, stall);
        end
        tick();
    endtask

    task automatic test_branch();
        drive_phase();
        clear_inputs();
        rs_d = 5'd3; tuse_rs_d = 2'd0; wa_e = 5'd3; tnew_e = 2'd1;
        #1;
        vectors++;
        if (stall !== 1'b1 || fwd_rs_d !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL branch_stall: got stall=%b fwd_rs_d=%0d want 1/0", stall, fwd_rs_d);
        end
        tick();
        drive_phase();
        wa_e = 5'd0; tnew_e = 2'd0; wa_m = 5'd3; tnew_m = 2'd0;
        #1;
        vectors++;
        if (stall !== 1'b0 || fwd_rs_d !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL branch_fwd_m: got stall=%b fwd_rs_d=%0d want 0/1", stall, fwd_rs_d);
        end
        tick();
    endtask

    task automatic test_forward_priority();
        drive_phase();
        clear_inputs();
        wa_m = 5'd5; wa_w = 5'd5; tnew_m = 2'd0; rs_e = 5'd5; rt_e = 5'd5;
        #1;
        vectors++;
        if (fwd_rs_e !== 2'd1 || fwd_rt_e !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL fwd_m_priority: got rs=%0d rt=%0d want 1/1", fwd_rs_e, fwd_rt_e);
        end
        drive_phase();
        wa_m = 5'd0;
        #1;
        vectors++;
        if (fwd_rs_e !== 2'd2 || fwd_rt_e !== 2'd2) begin
            miscompares++;
            $display("[TB] FAIL fwd_w_fallback: got rs=%0d rt=%0d want 2/2", fwd_rs_e, fwd_rt_e);
        end
        drive_phase();
        rs_e = 5'd0; wa_w = 5'd0;
        #1;
        vectors++;
        if (fwd_rs_e !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL fwd_reg_zero: got %0d want 0", fwd_rs_e);
        end
        drive_phase();
        clear_inputs();
        rs_d = 5'd0; rt_d = 5'd0; tuse_rs_d = 0; tuse_rt_d = 0; wa_e = 5'd0; tnew_e = 2'd2;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL zero_reg_no_stall: got %b want 0", stall);
        end
        drive_phase();
        rs_d = 5'd9; tuse_rs_d = 2'd3; wa_e = 5'd9;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL tuse3_no_stall: got %b want 0", stall);
        end
        tick();
    endtask

    task automatic test_store();
        drive_phase();
        clear_inputs();
        rt_d = 5'd7; tuse_rt_d = 2'd2; wa_e = 5'd7; tnew_e = 2'd2;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL store_no_stall: got %b want 0", stall);
        end
        tick();
        drive_phase();
        clear_inputs();
        rt_e = 5'd7; wa_w = 5'd7;
        #1;
        vectors++;
        if (fwd_rt_e !== 2'd2) begin
            miscompares++;
            $display("[TB] FAIL store_fwd_rt_e: got %0d want 2", fwd_rt_e);
        end
        tick();
    endtask

    task automatic test_div_busy();
        int busy_cycles;
        drive_phase();
        clear_inputs();
        md_start_e = 1'b1; md_is_div_e = 1'b1; md_use_d = 1'b1;
        #1;
        vectors++;
        if (stall !== 1'b1 || md_busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL div_start: got stall=%b busy=%b want 1/0", stall, md_busy);
        end
        tick();
        busy_cycles = 0;
        for (int k = 0; k < DIV_N + 3; k++) begin
            drive_phase();
            md_start_e = 1'b0;
            #1;
            if (md_busy === 1'b1) busy_cycles++;
            vectors++;
            if (stall !== md_busy || md_busy !== (k < DIV_N)) begin
                miscompares++;
                $display("[TB] FAIL div_busy_cycle%0d: got stall=%b busy=%b want busy=%b",
                         k, stall, md_busy, k < DIV_N);
            end
            tick();
        end
        vectors++;
        if (busy_cycles != DIV_N) begin
            miscompares++;
            $display("[TB] FAIL div_busy_length: got %0d want %0d", busy_cycles, DIV_N);
        end
    endtask

    task automatic test_mult_reset();
        drive_phase();
        clear_inputs();
        md_start_e = 1'b1; md_is_div_e = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            drive_phase();
            md_start_e = 1'b0;
            #1;
            vectors++;
            if (md_busy !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL mult_busy_cycle%0d: got %b want 1", k, md_busy);
            end
            tick();
        end
        drive_phase();
        rst = 1'b1;
        tick();
        drive_phase();
        rst = 1'b0; md_use_d = 1'b1;
        #1;
        vectors++;
        if (md_busy !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mult_reset_abort: got busy=%b stall=%b want 0/0", md_busy, stall);
        end
        tick();
    endtask

    task automatic test_random();
        logic [10:0] exp_v;
        logic [10:0] obs_v;
        for (int n = 0; n < 600; n++) begin
            drive_phase();
            rst = ($urandom_range(0, 59) == 0);
            rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
            rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
            wa_e = 5'($urandom_range(0, 3)); wa_m = 5'($urandom_range(0, 3));
            wa_w = 5'($urandom_range(0, 3));
            tuse_rs_d = 2'($urandom); tuse_rt_d = 2'($urandom);
            tnew_e = 2'($urandom_range(0, 2)); tnew_m = 2'($urandom_range(0, 1));
            md_start_e = ($urandom_range(0, 7) == 0);
            md_is_div_e = 1'($urandom);
            md_use_d = ($urandom_range(0, 2) == 0);
            #1;
            exp_v = m_expected();
            obs_v = {stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy};
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL random_vec%0d: got %b want %b (stall,flush,fwd_rs_d,fwd_rt_d,fwd_rs_e,fwd_rt_e,busy)",
                         n, obs_v, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_forward_priority();
        test_store();
        test_div_busy();
        test_mult_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
